// File: rtl/core_pipe_mem.sv
// core_pipe_mem: memory stage; issues dmem requests, detects misalignment, owns the s3 register.
module core_pipe_mem #(
  parameter int XLEN       = 64,
  parameter int MEM_ADDR_W = 64,
  parameter int LSU_OP_W   = 7,
  parameter int CSR_OP_W   = 3,
  parameter int CSR_ADDR_W = 12,
  parameter int CFU_OP_W   = 3,
  parameter int WB_OP_W    = 2
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  flush,
  input  logic                  s2_valid,
  output logic                  s2_ready,
  input  logic [XLEN-1:0]       s2_pc,
  input  logic [XLEN-1:0]       s2_n_pc,
  input  logic [31:0]           s2_instr,
  input  logic [XLEN-1:0]       s2_wdata,
  input  logic [XLEN-1:0]       s2_sdata,
  input  logic [4:0]            s2_rd,
  input  logic [LSU_OP_W-1:0]   s2_lsu_op,
  input  logic [CSR_OP_W-1:0]   s2_csr_op,
  input  logic [CSR_ADDR_W-1:0] s2_csr_addr,
  input  logic [CFU_OP_W-1:0]   s2_cfu_op,
  input  logic [WB_OP_W-1:0]    s2_wb_op,
  input  logic                  s2_trap,
  output logic                  s3_valid,
  input  logic                  s3_ready,
  output logic                  s3_full,
  output logic [XLEN-1:0]       s3_pc,
  output logic [XLEN-1:0]       s3_n_pc,
  output logic [31:0]           s3_instr,
  output logic [XLEN-1:0]       s3_wdata,
  output logic [XLEN-1:0]       s3_sdata,
  output logic [4:0]            s3_rd,
  output logic [LSU_OP_W-1:0]   s3_lsu_op,
  output logic [CSR_OP_W-1:0]   s3_csr_op,
  output logic [CSR_ADDR_W-1:0] s3_csr_addr,
  output logic [CFU_OP_W-1:0]   s3_cfu_op,
  output logic [WB_OP_W-1:0]    s3_wb_op,
  output logic                  s3_trap,
  output logic                  dmem_req,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic                  dmem_wen,
  output logic [7:0]            dmem_strb,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_gnt
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;
  logic kill;
  logic [2:0] off;
  logic is_load, is_store, lsu, mis, trap, mem;
  logic [7:0] strb_base;
  logic [4:0] rd_nxt;
  assign off       = s2_wdata[2:0];
  assign is_load   = s2_lsu_op[0];
  assign is_store  = s2_lsu_op[1];
  assign lsu       = is_load || is_store;
  assign mis       = lsu && ((s2_lsu_op[3] && off[0]) || (s2_lsu_op[4] && off[1:0] != 2'b00) ||
                             (s2_lsu_op[5] && off != 3'b000));
  assign trap      = s2_trap || mis;
  assign mem       = lsu && !trap;
  assign strb_base = s2_lsu_op[2] ? 8'h01 : s2_lsu_op[3] ? 8'h03 : s2_lsu_op[4] ? 8'h0F :
                     s2_lsu_op[5] ? 8'hFF : 8'h00;
  // Upstream trap causes win over the local misalignment cause.
  assign rd_nxt    = s2_trap ? s2_rd : mis ? (is_load ? 5'd4 : 5'd6) : s2_rd;
  assign dmem_addr  = dmem_req ? (MEM_ADDR_W'(s2_wdata) & ~MEM_ADDR_W'(7)) : '0;
  assign dmem_wen   = dmem_req && is_store;
  assign dmem_strb  = dmem_req ? strb_base << off : 8'h00;
  assign dmem_wdata = dmem_req ? s2_sdata << {off, 3'b000} : '0;
  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    s3_valid  = 1'b0;
    s2_ready  = 1'b0;
    if (state == REQ) begin
      dmem_req  = 1'b1;
      s2_ready  = dmem_gnt;
      s3_valid  = dmem_gnt && !kill && !flush && s3_ready;
      state_nxt = dmem_gnt ? IDLE : REQ;
    end else if (mem) begin
      dmem_req  = s2_valid && s3_ready && !flush;
      s3_valid  = dmem_req && dmem_gnt;
      s2_ready  = s3_valid || flush;
      state_nxt = (dmem_req && !dmem_gnt) ? REQ : IDLE;
    end else begin
      s3_valid = s2_valid && !flush;
      s2_ready = s3_ready || flush;
    end
    if (g_reset) begin
      state_nxt = IDLE;
      dmem_req  = 1'b0;
      s3_valid  = 1'b0;
      s2_ready  = 1'b0;
    end
  end
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state       <= IDLE;
      kill        <= 1'b0;
      s3_full     <= 1'b0;
      s3_pc       <= '0;
      s3_n_pc     <= '0;
      s3_instr    <= '0;
      s3_wdata    <= '0;
      s3_sdata    <= '0;
      s3_rd       <= '0;
      s3_lsu_op   <= '0;
      s3_csr_op   <= '0;
      s3_csr_addr <= '0;
      s3_cfu_op   <= '0;
      s3_wb_op    <= '0;
      s3_trap     <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= (state == REQ) && !dmem_gnt && (kill || flush);
      if (s3_ready || flush) s3_full <= s3_valid;
      if (s3_valid && s3_ready) begin
        s3_pc       <= s2_pc;
        s3_n_pc     <= s2_n_pc;
        s3_instr    <= s2_instr;
        s3_wdata    <= s2_wdata;
        s3_sdata    <= s2_sdata;
        s3_rd       <= rd_nxt;
        s3_lsu_op   <= s2_lsu_op;
        s3_csr_op   <= s2_csr_op;
        s3_csr_addr <= s2_csr_addr;
        s3_cfu_op   <= s2_cfu_op;
        s3_wb_op    <= s2_wb_op;
        s3_trap     <= trap;
      end
    end
  end
endmodule

// File: tb/tb_core_pipe_mem.sv
// tb_core_pipe_mem: directed and randomized checks of the memory stage against a size/offset model.
module tb_core_pipe_mem;
  localparam logic [6:0] LOAD = 7'h01, STORE = 7'h02, BYTE = 7'h04, HALF = 7'h08,
                         WORD = 7'h10, DOUBLE = 7'h20;
  logic g_clk = 0, g_reset = 1, flush = 0, s2_valid = 0, s2_ready, s3_valid, s3_ready = 1, s3_full;
  logic [63:0] s2_pc = 0, s2_n_pc = 0, s2_wdata = 0, s2_sdata = 0;
  logic [31:0] s2_instr = 0;
  logic [4:0] s2_rd = 0;
  logic [6:0] s2_lsu_op = 0;
  logic [2:0] s2_csr_op = 0, s2_cfu_op = 0;
  logic [11:0] s2_csr_addr = 0;
  logic [1:0] s2_wb_op = 0;
  logic s2_trap = 0;
  logic [63:0] s3_pc, s3_n_pc, s3_wdata, s3_sdata;
  logic [31:0] s3_instr;
  logic [4:0] s3_rd;
  logic [6:0] s3_lsu_op;
  logic [2:0] s3_csr_op, s3_cfu_op;
  logic [11:0] s3_csr_addr;
  logic [1:0] s3_wb_op;
  logic s3_trap, dmem_req, dmem_wen, dmem_gnt = 0;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0] dmem_strb;
  int tests = 0, failed = 0;

  core_pipe_mem dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .s2_valid(s2_valid), .s2_ready(s2_ready),
    .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_instr(s2_instr), .s2_wdata(s2_wdata),
    .s2_sdata(s2_sdata), .s2_rd(s2_rd), .s2_lsu_op(s2_lsu_op), .s2_csr_op(s2_csr_op),
    .s2_csr_addr(s2_csr_addr), .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op), .s2_trap(s2_trap),
    .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_full(s3_full), .s3_pc(s3_pc),
    .s3_n_pc(s3_n_pc), .s3_instr(s3_instr), .s3_wdata(s3_wdata), .s3_sdata(s3_sdata),
    .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op), .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr),
    .s3_cfu_op(s3_cfu_op), .s3_wb_op(s3_wb_op), .s3_trap(s3_trap), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt)
  );

  always #5 g_clk = ~g_clk;

  // Reference: an access of N bytes at address a is aligned iff a % N == 0.
  function automatic void ref_mem(input logic [63:0] a, input logic [63:0] sd, input logic [6:0] op,
                                  output logic mis, output logic [63:0] addr,
                                  output logic [7:0] strb, output logic [63:0] wd);
    int size, o;
    size = op[2] ? 1 : op[3] ? 2 : op[4] ? 4 : 8;
    o    = int'(a % 8);
    mis  = (a % 64'(size)) != 0;
    addr = a - 64'(o);
    strb = 8'(((1 << size) - 1) << o);
    wd   = sd << (8 * o);
  endfunction

  task automatic drive(input logic [63:0] wd, input logic [63:0] sd, input logic [6:0] op,
                       input logic [4:0] rd, input logic trap);
    s2_valid = 1; s2_wdata = wd; s2_sdata = sd; s2_lsu_op = op; s2_rd = rd; s2_trap = trap;
    s2_pc = {$urandom, $urandom}; s2_n_pc = s2_pc + 4; s2_instr = $urandom;
  endtask

  task automatic test_reset;
    drive(64'h1008, 64'h55, LOAD | DOUBLE, 5'd3, 0);
    dmem_gnt = 1;
    #2;
    tests++;
    if ({s3_valid, s2_ready, dmem_req, s3_full, dmem_strb, dmem_addr, s3_wdata, s3_trap} !== '0) begin
      failed++;
      $display("FAIL reset: valid/ready/req/full=%b%b%b%b strb=%h addr=%h s3_wdata=%h, want all 0",
               s3_valid, s2_ready, dmem_req, s3_full, dmem_strb, dmem_addr, s3_wdata);
    end
    s2_valid = 0; dmem_gnt = 0;
    @(posedge g_clk); #1 g_reset = 0;
  endtask

  task automatic test_add;
    drive(64'h5, 64'h0, 7'h0, 5'd10, 0);
    @(negedge g_clk);
    tests++;
    if ({dmem_req, s3_valid, s2_ready} !== 3'b011) begin
      failed++; $display("FAIL add_hs: req/s3_valid/s2_ready=%b%b%b want 011", dmem_req, s3_valid, s2_ready);
    end
    @(posedge g_clk); #1 s2_valid = 0;
    tests++;
    if ({s3_full, s3_wdata, s3_rd, s3_trap} !== {1'b1, 64'h5, 5'd10, 1'b0}) begin
      failed++; $display("FAIL add_s3: full=%b wdata=%h rd=%0d trap=%b want 1 5 10 0", s3_full, s3_wdata, s3_rd, s3_trap);
    end
  endtask

  task automatic test_sb;
    drive(64'h1003, 64'hAB, STORE | BYTE, 5'd0, 0);
    dmem_gnt = 1;
    @(negedge g_clk);
    tests++;
    if ({dmem_req, dmem_wen, dmem_addr, dmem_strb, dmem_wdata, s3_valid} !==
        {1'b1, 1'b1, 64'h1000, 8'h08, 64'hAB000000, 1'b1}) begin
      failed++; $display("FAIL sb: req=%b wen=%b addr=%h strb=%h wdata=%h s3_valid=%b want 1 1 1000 08 ab000000 1",
                         dmem_req, dmem_wen, dmem_addr, dmem_strb, dmem_wdata, s3_valid);
    end
    @(posedge g_clk); #1 s2_valid = 0; dmem_gnt = 0;
  endtask

  task automatic test_lw_mis;
    drive(64'h2002, 64'h0, LOAD | WORD, 5'd9, 0);
    dmem_gnt = 1;
    @(negedge g_clk);
    tests++;
    if ({dmem_req, s3_valid} !== 2'b01) begin
      failed++; $display("FAIL lw_mis_req: req=%b s3_valid=%b want 0 1", dmem_req, s3_valid);
    end
    @(posedge g_clk); #1 s2_valid = 0; dmem_gnt = 0;
    tests++;
    if ({s3_trap, s3_rd} !== {1'b1, 5'd4}) begin
      failed++; $display("FAIL lw_mis_s3: trap=%b rd=%0d want 1 4", s3_trap, s3_rd);
    end
  endtask

  task automatic test_ld_stall;
    int xfers = 0;
    drive(64'h3000, 64'h0, LOAD | DOUBLE, 5'd7, 0);
    for (int c = 0; c < 4; c++) begin
      dmem_gnt = (c == 3);
      @(negedge g_clk);
      tests++;
      if ({dmem_req, dmem_addr, dmem_strb, s2_ready} !== {1'b1, 64'h3000, 8'hFF, dmem_gnt}) begin
        failed++; $display("FAIL ld_stall c%0d: req=%b addr=%h strb=%h s2_ready=%b want 1 3000 ff %b",
                           c, dmem_req, dmem_addr, dmem_strb, s2_ready, dmem_gnt);
      end
      if (s3_valid && s3_ready) xfers++;
      @(posedge g_clk); #1;
    end
    s2_valid = 0; dmem_gnt = 0;
    @(negedge g_clk);
    if (s3_valid) xfers++;
    tests++;
    if ({xfers, dmem_req, s3_rd} !== {32'd1, 1'b0, 5'd7}) begin
      failed++; $display("FAIL ld_stall_xfer: transfers=%0d req=%b rd=%0d want 1 0 7", xfers, dmem_req, s3_rd);
    end
  endtask

  task automatic test_flush;
    @(posedge g_clk); #1;
    drive(64'h3008, 64'h0, LOAD | DOUBLE, 5'd8, 0);
    dmem_gnt = 0;
    @(posedge g_clk); #1 flush = 1;
    @(posedge g_clk); #1 flush = 0; dmem_gnt = 1;
    @(negedge g_clk);
    tests++;
    if ({s3_valid, s2_ready, dmem_req} !== 3'b011) begin
      failed++; $display("FAIL flush_kill: s3_valid=%b s2_ready=%b req=%b want 0 1 1", s3_valid, s2_ready, dmem_req);
    end
    @(posedge g_clk); #1 dmem_gnt = 0;
    tests++;
    if ({s3_full, s3_rd} !== {1'b0, 5'd7}) begin
      failed++; $display("FAIL flush_s3: full=%b rd=%0d want 0 7", s3_full, s3_rd);
    end
    drive(64'h77, 64'h0, 7'h0, 5'd2, 0);
    flush = 1;
    @(negedge g_clk);
    tests++;
    if ({s3_valid, s2_ready} !== 2'b01) begin
      failed++; $display("FAIL flush_alu: s3_valid=%b s2_ready=%b want 0 1", s3_valid, s2_ready);
    end
    @(posedge g_clk); #1 flush = 0; s2_valid = 0;
  endtask

  task automatic test_backpressure;
    drive(64'h99, 64'h0, 7'h0, 5'd11, 0);
    @(posedge g_clk); #1;
    s3_ready = 0;
    drive(64'h123, 64'h0, 7'h0, 5'd12, 0);
    @(negedge g_clk);
    tests++;
    if ({s3_valid, s2_ready} !== 2'b10) begin
      failed++; $display("FAIL bp_alu: s3_valid=%b s2_ready=%b want 1 0", s3_valid, s2_ready);
    end
    @(posedge g_clk); #1;
    tests++;
    if ({s3_full, s3_wdata} !== {1'b1, 64'h99}) begin
      failed++; $display("FAIL bp_hold: full=%b wdata=%h want 1 99", s3_full, s3_wdata);
    end
    drive(64'h4000, 64'h0, LOAD | WORD, 5'd1, 0);
    dmem_gnt = 1;
    @(negedge g_clk);
    tests++;
    if ({dmem_req, s3_valid, s2_ready} !== 3'b000) begin
      failed++; $display("FAIL bp_lsu: req=%b s3_valid=%b s2_ready=%b want 000", dmem_req, s3_valid, s2_ready);
    end
    @(posedge g_clk); #1 s3_ready = 1; s2_valid = 0; dmem_gnt = 0;
  endtask

  task automatic test_back_to_back;
    drive(64'h4002, 64'h0, LOAD | HALF, 5'd13, 0);
    dmem_gnt = 1;
    @(negedge g_clk);
    tests++;
    if ({s3_valid, s2_ready, dmem_strb} !== {2'b11, 8'h0C}) begin
      failed++; $display("FAIL b2b_lh: s3_valid=%b s2_ready=%b strb=%h want 1 1 0c", s3_valid, s2_ready, dmem_strb);
    end
    @(posedge g_clk); #1;
    drive(64'hBEEF, 64'h0, 7'h0, 5'd14, 0);
    @(negedge g_clk);
    tests++;
    if ({s3_valid, s2_ready, s3_rd} !== {2'b11, 5'd13}) begin
      failed++; $display("FAIL b2b_add: s3_valid=%b s2_ready=%b s3_rd=%0d want 1 1 13", s3_valid, s2_ready, s3_rd);
    end
    @(posedge g_clk); #1 s2_valid = 0; dmem_gnt = 0;
    tests++;
    if ({s3_wdata, s3_rd} !== {64'hBEEF, 5'd14}) begin
      failed++; $display("FAIL b2b_s3: wdata=%h rd=%0d want beef 14", s3_wdata, s3_rd);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      int kind, sz;
      logic [63:0] a, sd, ea, ew, pc;
      logic [6:0] op;
      logic [7:0] es;
      logic [4:0] rd, erd;
      logic trp, mis, mem, done;
      kind = $urandom_range(0, 2);
      sz   = $urandom_range(0, 3);
      a    = {$urandom, $urandom};
      sd   = {$urandom, $urandom};
      rd   = 5'($urandom);
      trp  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << sz) - 1);
      op = (kind == 0) ? 7'h0 : ((kind == 1) ? LOAD : STORE) | 7'(BYTE << sz);
      ref_mem(a, sd, op, mis, ea, es, ew);
      mis = mis && kind != 0;
      mem = kind != 0 && !mis && !trp;
      erd = trp ? rd : mis ? ((kind == 1) ? 5'd4 : 5'd6) : rd;
      drive(a, sd, op, rd, trp);
      pc = s2_pc;
      dmem_gnt = 1'($urandom_range(0, 1));
      done = 0;
      for (int c = 0; c < 12 && !done; c++) begin
        if (c >= 4) dmem_gnt = 1;
        @(negedge g_clk);
        tests++;
        if (mem) begin
          if ({dmem_req, dmem_wen, dmem_addr, dmem_strb, dmem_wdata, s2_ready, s3_valid} !==
              {1'b1, kind == 2, ea, es, ew, dmem_gnt, dmem_gnt}) begin
            failed++; $display("FAIL rnd%0d_mem c%0d: req=%b wen=%b addr=%h strb=%h wdata=%h rdy=%b v=%b want 1 %b %h %h %h %b %b",
                               i, c, dmem_req, dmem_wen, dmem_addr, dmem_strb, dmem_wdata, s2_ready, s3_valid,
                               kind == 2, ea, es, ew, dmem_gnt, dmem_gnt);
          end
          done = dmem_gnt;
        end else begin
          if ({dmem_req, s2_ready, s3_valid} !== 3'b011) begin
            failed++; $display("FAIL rnd%0d_pass: req=%b rdy=%b v=%b want 011", i, dmem_req, s2_ready, s3_valid);
          end
          done = 1;
        end
        @(posedge g_clk); #1;
        if (!done) dmem_gnt = 1'($urandom_range(0, 1));
      end
      tests++;
      if ({s3_full, s3_pc, s3_wdata, s3_sdata, s3_rd, s3_trap, s3_lsu_op} !==
          {1'b1, pc, a, sd, erd, trp || mis, op}) begin
        failed++; $display("FAIL rnd%0d_s3: full=%b pc=%h wdata=%h rd=%0d trap=%b op=%h want 1 %h %h %0d %b %h",
                           i, s3_full, s3_pc, s3_wdata, s3_rd, s3_trap, s3_lsu_op, pc, a, erd, trp || mis, op);
      end
    end
    s2_valid = 0; dmem_gnt = 0;
  endtask

  task automatic test_reset_in_req;
    @(posedge g_clk); #1;
    drive(64'h5000, 64'h0, LOAD | DOUBLE, 5'd5, 0);
    dmem_gnt = 0;
    @(posedge g_clk); #1;
    tests++;
    if (dmem_req !== 1'b1) begin
      failed++; $display("FAIL req_pending: req=%b want 1", dmem_req);
    end
    s2_valid = 0;
    #1 g_reset = 1;
    #1;
    tests++;
    if ({dmem_req, s3_full, s2_ready} !== 3'b000) begin
      failed++; $display("FAIL reset_in_req: req=%b full=%b rdy=%b want 000", dmem_req, s3_full, s2_ready);
    end
    @(posedge g_clk); #1 g_reset = 0;
    @(negedge g_clk);
    tests++;
    if (dmem_req !== 1'b0) begin
      failed++; $display("FAIL idle_after_reset: req=%b want 0", dmem_req);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sb;
    test_lw_mis;
    test_ld_stall;
    test_flush;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_reset_in_req;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
